// File: rtl/tile_row_fetcher.sv
// Tile ROM reader: fetches one 64-bit row per request into a prefetch buffer and
// serialises it pixel by pixel. Optional horizontal mirroring via TILE_ROW_FETCHER_MIRROR_EN.
module tile_row_fetcher #(
    parameter int PIXEL_BITS      = 4,
    parameter int TILE_WIDTH      = 16,
    parameter int TILE_INDEX_BITS = 5,
    parameter int ROW_INDEX_BITS  = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [TILE_INDEX_BITS-1:0]       req_tile,
    input  logic [ROW_INDEX_BITS-1:0]        req_row,
`ifdef TILE_ROW_FETCHER_MIRROR_EN
    input  logic                             req_hflip,
`endif
    output logic                             rom_read,
    output logic [TILE_INDEX_BITS-1:0]       rom_tile_index,
    output logic [ROW_INDEX_BITS-1:0]        rom_row_index,
    input  logic [PIXEL_BITS*TILE_WIDTH-1:0] rom_dout,
    input  logic                             pixel_enable,
    output logic [PIXEL_BITS-1:0]            pixel,
    output logic                             pixel_valid,
    output logic                             underrun
);

    localparam int CNT_W = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TILE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;
    typedef logic [TILE_WIDTH-1:0][PIXEL_BITS-1:0] row_t;

    state_t                      state_q, state_d;
    logic                        rom_read_q, rom_read_d;
    logic [TILE_INDEX_BITS-1:0]  tile_q, tile_d;
    logic [ROW_INDEX_BITS-1:0]   row_q, row_d;
    logic                        req_flip_q, req_flip_d;
    row_t                        buf_row_q, buf_row_d;
    logic                        buf_full_q, buf_full_d;
    logic                        buf_flip_q, buf_flip_d;
    row_t                        sh_row_q, sh_row_d;
    logic                        sh_valid_q, sh_valid_d;
    logic                        sh_flip_q, sh_flip_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        underrun_q, underrun_d;
    logic                        flip_in;
    logic                        accept;
    logic                        load;
    logic [CNT_W-1:0]            lane;

`ifdef TILE_ROW_FETCHER_MIRROR_EN
    assign flip_in = req_hflip;
`else
    assign flip_in = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !buf_full_q && !flush;
    assign accept    = req_valid && req_ready;

    // Buffer -> shifter transfer: fill an empty shifter, or chain on the last pixel.
    assign load = buf_full_q && (!sh_valid_q || (pixel_enable && count_q == LAST));

    always_comb begin
        state_d    = state_q;
        rom_read_d = 1'b0;
        tile_d     = tile_q;
        row_d      = row_q;
        req_flip_d = req_flip_q;
        buf_row_d  = buf_row_q;
        buf_full_d = buf_full_q;
        buf_flip_d = buf_flip_q;
        sh_row_d   = sh_row_q;
        sh_valid_d = sh_valid_q;
        sh_flip_d  = sh_flip_q;
        count_d    = count_q;
        underrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = FETCH;
                    rom_read_d = 1'b1;
                    tile_d     = req_tile;
                    row_d      = req_row;
                    req_flip_d = flip_in;
                end
            end
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                state_d    = IDLE;
                buf_row_d  = rom_dout;
                buf_full_d = 1'b1;
                buf_flip_d = req_flip_q;
            end
            default: state_d = IDLE;
        endcase

        // A capture and a buffer drain never coincide: capture needs the buffer empty at accept.
        if (load) begin
            sh_row_d   = buf_row_q;
            sh_flip_d  = buf_flip_q;
            sh_valid_d = 1'b1;
            count_d    = '0;
            buf_full_d = 1'b0;
        end else if (sh_valid_q && pixel_enable) begin
            if (count_q != LAST) begin
                count_d = count_q + 1'b1;
            end else begin
                sh_valid_d = 1'b0;
                count_d    = '0;
                underrun_d = 1'b1;
            end
        end

        if (flush) begin
            state_d    = IDLE;
            rom_read_d = 1'b0;
            buf_full_d = 1'b0;
            sh_valid_d = 1'b0;
            count_d    = '0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rom_read_q <= 1'b0;
            tile_q     <= '0;
            row_q      <= '0;
            req_flip_q <= 1'b0;
            buf_row_q  <= '0;
            buf_full_q <= 1'b0;
            buf_flip_q <= 1'b0;
            sh_row_q   <= '0;
            sh_valid_q <= 1'b0;
            sh_flip_q  <= 1'b0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_read_q <= rom_read_d;
            tile_q     <= tile_d;
            row_q      <= row_d;
            req_flip_q <= req_flip_d;
            buf_row_q  <= buf_row_d;
            buf_full_q <= buf_full_d;
            buf_flip_q <= buf_flip_d;
            sh_row_q   <= sh_row_d;
            sh_valid_q <= sh_valid_d;
            sh_flip_q  <= sh_flip_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
        end
    end

    // Lane 0 is the LS nibble; unflipped rows start from the MS nibble.
    assign lane = sh_flip_q ? count_q : (LAST - count_q);

    assign rom_read       = rom_read_q;
    assign rom_tile_index = tile_q;
    assign rom_row_index  = row_q;
    assign pixel_valid    = sh_valid_q;
    assign pixel          = sh_valid_q ? sh_row_q[lane] : '0;
    assign underrun       = underrun_q;

endmodule

// File: doc/tile_row_fetcher.md
Name: tile_row_fetcher

Overview:
- Reader/consumer side of the tile ROM interface: accepts (tile, row) requests from the tile-map walker and drives the ROM read strobe and address.
- Captures the 64-bit row word one cycle after the read, then serialises it as 16 x 4-bit pixels to the video output stage, one pixel per pixel_enable.
- Double-buffered: a one-row prefetch buffer feeds the pixel shifter, so output continues across tile boundaries without gaps when requests arrive in time.

Parameters:
- PIXEL_BITS, 4, bits per pixel.
- TILE_WIDTH, 16, pixels per tile row; ROM word width is PIXEL_BITS*TILE_WIDTH = 64.
- TILE_INDEX_BITS, 5, tile index width (32 tiles).
- ROW_INDEX_BITS, 4, row index width (16 rows).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous line-start flush; discards all buffered and in-flight data.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_tile  in  5  tile index of request.
- req_row  in  4  row within tile.
- rom_read  out  1  ROM read strobe, registered.
- rom_tile_index  out  5  ROM tile address, registered.
- rom_row_index  out  4  ROM row address, registered.
- rom_dout  in  64  ROM data, valid the cycle after rom_read.
- pixel_enable  in  1  advance to the next pixel (from video timing).
- pixel  out  4  current pixel; 0 when pixel_valid=0.
- pixel_valid  out  1  shifter holds a valid row.
- underrun  out  1  one-cycle pulse; shifter ran dry.

Behaviour:
- Reset values: req_ready=1, rom_read=0, rom_tile_index=0, rom_row_index=0, pixel=0, pixel_valid=0, underrun=0, buf_full=0, count=0; FSM in IDLE.
- Fetch FSM has three states: IDLE, FETCH, CAPTURE.
- req_ready is combinational: 1 only when the FSM is in IDLE, buf_full=0 and flush=0.
- IDLE -> FETCH on accept:
  - the accept edge loads req_tile/req_row into rom_tile_index/rom_row_index;
  - rom_read=1 for exactly the FETCH cycle.
- FETCH -> CAPTURE unconditionally. The ROM samples the address at the end of the FETCH cycle.
- CAPTURE -> IDLE. rom_dout is latched into the row buffer and buf_full is set.
- Latency: accept in cycle A; rom_read in A+1; capture at the end of A+2; buf_full=1 from A+3.
- Shifter holds a 64-bit row plus a 4-bit count:
  - pixel = row[63-4*count -: 4], so pixel 0 is the MS nibble;
  - pixel_valid = shifter loaded.
- Load rules:
  - If the shifter is empty and buf_full=1, load the buffer immediately (no pixel_enable needed), set count=0, clear buf_full.
  - On pixel_enable with valid and count<15: count++.
  - On pixel_enable with valid and count==15, and buf_full=1: reload from the buffer, count=0, clear buf_full, no gap.
  - On pixel_enable with valid and count==15, and buf_full=0: shifter goes empty, pixel_valid=0, underrun pulses the next cycle.
- pixel_enable while the shifter is empty: ignored, with no underrun pulse.
- Simultaneous buffer load and capture cannot occur:
  - a capture requires buf_full=0 at accept;
  - the buffer is only drained when buf_full=1.
- flush has highest priority. On the next edge it:
  - sets the FSM to IDLE and clears rom_read;
  - clears buf_full and the shifter, sets count=0;
  - discards an in-flight CAPTURE (rom_dout ignored).
- While flush=1, no request is accepted.
- Async reset mid-fetch: everything returns to reset values immediately; a pending ROM word is never captured.
- Wrap-around: count wraps 15 -> 0 only on reload; there is no modular wrap otherwise.

Optional Feature:
- Macro: TILE_ROW_FETCHER_MIRROR_EN.
- When defined:
  - adds input req_hflip (1 bit), stored with each request alongside the buffered row;
  - a flipped row outputs pixels LS nibble first: pixel = row[4*count +: 4];
  - the flip attribute follows the row from buffer to shifter.
- When undefined: the port is absent and the order is always MS nibble first.

Test Plan:
- Reset, then request tile=3 row=7 with rom_dout=64'h0123456789ABCDEF:
  - rom_read high in exactly one cycle, with address 3/7;
  - pixel_valid rises;
  - with pixel_enable held high, pixels 0,1,...,F in consecutive cycles, then pixel_valid=0 and one underrun pulse.
- Second request issued during the first row's output, with ROM returning 64'hFFFF...; pixel_enable continuous:
  - 32 consecutive valid pixels, no gap;
  - req_ready low from accept until the buffer drains.
- pixel_enable toggling every other cycle:
  - each pixel held for 2 cycles;
  - count advances only on enable.
- flush asserted in the CAPTURE cycle:
  - buf_full stays 0;
  - pixel_valid stays 0;
  - req_ready=1 the cycle after flush deasserts.
- reset_n pulsed low mid-row (count=9): all outputs zero asynchronously; the next request behaves as in the first scenario.
- With TILE_ROW_FETCHER_MIRROR_EN defined, req_hflip=1 and rom_dout=64'h0123456789ABCDEF: pixels F,E,...,0.
